xor_rot_decrypt_core: RTL and testbench

Iterative decryption engine for the team's lightweight 128-bit XOR/rotate block cipher. It is the receive-side inverse of the encrypt datapath. It accepts a ciphertext and key over a valid/ready handshake, regenerates the final round key, and runs the inverse rounds one per clock. It returns the plaintext over a second valid/ready handshake. It sits between the link receive buffer and the payload consumer.

---
 rtl/xor_rot_decrypt_core.sv | 152 +++++++++++++++
 tb/tb_xor_rot_decrypt_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xor_rot_decrypt_core.sv
// Iterative decryption core for the 128-bit XOR/rotate block cipher.
// Optional key cache enabled by defining KEY_CACHE_EN. Without it, every operation runs the full key expansion.
module xor_rot_decrypt_core #(
    parameter int unsigned NUM_ROUNDS = 8,
    parameter int unsigned ROT        = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_DONE} state_t;

    localparam logic [7:0] LP_N = 8'(NUM_ROUNDS);

    function automatic logic [127:0] rotl128(input logic [127:0] x, input int unsigned n);
        rotl128 = (x << n) | (x >> (32'd128 - n));
    endfunction

    function automatic logic [127:0] rotr128(input logic [127:0] x, input int unsigned n);
        rotr128 = (x >> n) | (x << (32'd128 - n));
    endfunction

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_cnt;
    logic [127:0] r_rk;
    logic [127:0] r_s;

    logic [7:0]   w_cnt_inc;
    logic [127:0] w_rk_fwd;
    logic [127:0] w_rk_prev;
    logic [127:0] w_s_mix;
    logic [127:0] w_s_round;
    logic         w_accept;
    logic         w_kexp_last;
    logic         w_round_last;
    logic         w_hit;

    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_rk_fwd     = rotl128(r_rk, 32'd29) ^ {120'b0, w_cnt_inc};
    assign w_rk_prev    = rotr128(r_rk ^ {120'b0, r_cnt}, 32'd29);
    assign w_s_mix      = {r_s[127:64], r_s[63:0] ^ r_s[127:64]};
    assign w_s_round    = rotr128(w_s_mix, ROT) ^ w_rk_prev;
    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_kexp_last  = (w_cnt_inc == LP_N);
    assign w_round_last = (r_cnt == 8'd1);

`ifdef KEY_CACHE_EN
    logic         r_cvalid;
    logic [127:0] r_ckey;
    logic [127:0] r_crk;

    assign w_hit = r_cvalid && (in_key == r_ckey);

    // Key is latched at a miss acceptance. The entry becomes valid only once rk[N] exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cvalid <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_cvalid <= 1'b0;
            r_ckey   <= in_key;
        end else if (r_state == S_KEXP && w_kexp_last) begin
            r_crk    <= w_rk_fwd;
            r_cvalid <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = w_hit ? S_ROUND : S_KEXP;
            S_KEXP:  if (w_kexp_last)  w_next = S_ROUND;
            S_ROUND: if (w_round_last) w_next = S_DONE;
            S_DONE:  if (out_ready)    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_KEXP:  busy      = 1'b1;
            S_ROUND: busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // The ciphertext waits in r_s during expansion, which avoids a separate capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rk  <= '0;
            r_s   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef KEY_CACHE_EN
                        if (w_hit) begin
                            r_rk  <= r_crk;
                            r_s   <= in_data ^ r_crk;
                            r_cnt <= LP_N;
                        end else begin
                            r_rk  <= in_key;
                            r_s   <= in_data;
                            r_cnt <= '0;
                        end
`else
                        r_rk  <= in_key;
                        r_s   <= in_data;
                        r_cnt <= '0;
`endif
                    end
                end
                S_KEXP: begin
                    r_rk  <= w_rk_fwd;
                    r_cnt <= w_cnt_inc;
                    if (w_kexp_last) r_s <= r_s ^ w_rk_fwd;
                end
                S_ROUND: begin
                    r_s   <= w_s_round;
                    r_rk  <= w_rk_prev;
                    r_cnt <= r_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_s;

endmodule

// File: tb/tb_xor_rot_decrypt_core.sv
// Directed and table-driven bench for xor_rot_decrypt_core; ciphertexts come from a forward-encrypt model.
// Expected latencies follow KEY_CACHE_EN when the bench is built with it.
module tb_xor_rot_decrypt_core;

    logic         clk;
    logic         rst;
    logic         in_valid,  in_valid1;
    logic         in_ready,  in_ready1;
    logic [127:0] in_data,   in_data1;
    logic [127:0] in_key,    in_key1;
    logic         out_valid, out_valid1;
    logic         out_ready, out_ready1;
    logic [127:0] out_data,  out_data1;
    logic         busy,      busy1;

    int unsigned  n_checks;
    int unsigned  n_errors;
    bit           mc_valid;
    logic [127:0] mc_key;

    xor_rot_decrypt_core #(.NUM_ROUNDS(8), .ROT(7)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    xor_rot_decrypt_core #(.NUM_ROUNDS(1), .ROT(7)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_key(in_key1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rotl(input logic [127:0] x, input int unsigned n);
        return (x << n) | (x >> (128 - n));
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key,
                                             input int unsigned nr, input int unsigned rot);
        logic [127:0] s;
        logic [127:0] rk;
        s  = pt;
        rk = key;
        for (int unsigned i = 0; i < nr; i++) begin
            s = rotl(s ^ rk, rot);
            s[63:0] = s[63:0] ^ s[127:64];
            rk = rotl(rk, 29) ^ {120'b0, 8'(i + 1)};
        end
        return s ^ rk;
    endfunction

    function automatic int unsigned exp_latency(input logic [127:0] key);
`ifdef KEY_CACHE_EN
        if (mc_valid && key == mc_key) return 8;
`endif
        return 16;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run8(input logic [127:0] key, input logic [127:0] pt, input int unsigned hold,
                        input bit pre, input string name);
        logic [127:0] ct;
        int unsigned  lat;
        int unsigned  elat;
        bit           stable;
        ct   = encrypt(pt, key, 8, 7);
        wait_idle();
        elat = exp_latency(key);
        in_valid  = 1'b1;
        in_data   = ct;
        in_key    = key;
        out_ready = pre;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        mc_valid = 1'b1;
        mc_key   = key;
        check({name, "_busy"}, {126'b0, busy, in_ready}, 128'b10);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 128'(lat), 128'(elat));
        check({name, "_data"}, out_data, pt);
        if (!pre) begin
            stable = 1'b1;
            for (int unsigned k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (!out_valid || out_data !== pt || in_ready) stable = 1'b0;
            end
            if (hold > 0) check({name, "_hold"}, 128'(stable), 128'b1);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_consume"}, {126'b0, out_valid, in_ready}, 128'b01);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int unsigned  hold;
        bit           pre;
    } vec_t;

    vec_t         tbl[5];
    logic [127:0] prev_key;
    logic [127:0] rkey;
    int unsigned  lat1;

    initial begin
        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0, 1'b0};
        tbl[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hfedcba98765432100123456789abcdef, 5, 1'b0};
        tbl[2] = '{'1, '0, 0, 1'b1};
        tbl[3] = '{'0, '1, 2, 1'b0};
        tbl[4] = '{128'h80000000000000000000000000000001, 128'h0123456789abcdef0123456789abcdef, 1, 1'b1};

        n_checks = 0; n_errors = 0; mc_valid = 1'b0; mc_key = '0;
        rst = 1'b1;
        in_valid = 1'b0;  in_data = '0;  in_key = '0;  out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_key1 = '0; out_ready1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ctl", {125'b0, in_ready, out_valid, busy}, 128'b100);
        check("rst_data", out_data, '0);
        check("rst_ctl1", {125'b0, in_ready1, out_valid1, busy1}, 128'b100);

        // known answer with a single round
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat1 = 0;
        while (!out_valid1 && lat1 < 100) begin
            @(posedge clk); #1;
            lat1++;
        end
        check("ka_lat", 128'(lat1), 128'd2);
        check("ka_data", out_data1, 128'h0200_0000_0000_0000_0000_0000_0000_0000);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("ka_consume", {126'b0, out_valid1, in_ready1}, 128'b01);

        for (int i = 0; i < 5; i++)
            run8(tbl[i].key, tbl[i].pt, tbl[i].hold, tbl[i].pre, $sformatf("tbl%0d", i));

        // reset landing in the middle of the inverse rounds
        wait_idle();
        in_valid = 1'b1;
        in_key   = tbl[2].key;
        in_data  = encrypt(128'h5a5a, tbl[2].key, 8, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mc_valid = 1'b0;
        check("midrst_ctl", {125'b0, in_ready, out_valid, busy}, 128'b100);
        check("midrst_data", out_data, '0);
        run8(tbl[2].key, 128'h5a5a, 0, 1'b0, "after_rst");

        prev_key = tbl[0].key;
        for (int i = 0; i < 1000; i++) begin
            rkey = (i % 4 == 3) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
            run8(rkey, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            prev_key = rkey;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
